// File: rtl/stream_fifo.sv
// Register-based first-word-fall-through valid/ready FIFO.
// Optional level/almost_full outputs under `define STREAM_FIFO_LEVEL_EN.
module stream_fifo #(
  parameter int DATA_WIDTH  = 2,
  parameter int DEPTH_LOG2  = 2,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
`ifdef STREAM_FIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
`endif
  input  logic                  out_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6) begin : g_bad_depth
    $error("stream_fifo: DEPTH_LOG2 out of range");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("stream_fifo: AFULL_LEVEL out of range");
  end

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic wr, rd;

  assign wr = in_valid & in_ready_q;
  assign rd = out_valid_q & out_ready;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    unique case ({wr, rd})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
  end

  // in_ready stays low until the first edge after reset release
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = (count_d != '0);
    unique case (state_q)
      ST_RESET: begin
        state_d    = ST_RUN;
        in_ready_d = (count_d != FULL_C);
      end
      ST_RUN: begin
        in_ready_d = (count_d != FULL_C);
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rptr_q];

`ifdef STREAM_FIFO_LEVEL_EN
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [CW-1:0] level_q;
  logic          afull_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= count_d;
      afull_q <= (count_d >= AFULL_C);
    end
  end

  assign level       = level_q;
  assign almost_full = afull_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed testbench for stream_fifo (DEPTH=4, DATA_WIDTH=2).
// Table vectors plus hand sequences for stall, streaming and reset.
module tb_stream_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef STREAM_FIFO_LEVEL_EN
  logic [2:0] level;
  logic       almost_full;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stream_fifo #(
    .DATA_WIDTH (2),
    .DEPTH_LOG2 (2),
    .AFULL_LEVEL(3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
`ifdef STREAM_FIFO_LEVEL_EN
    .level      (level),
    .almost_full(almost_full),
`endif
    .out_ready  (out_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct packed {
    logic       iv;
    logic [1:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic       cd;
    logic [1:0] od;
    logic [2:0] lv;
    logic       af;
  } vec_t;

  vec_t tbl [11];
  logic [1:0] rx [$];

  initial begin
    //            iv id    or   ir   ov   cd   od    lv  af
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 3'd1, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 3'd2, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 3'd3, 1'b1};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd4, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd4, 1'b1};
    tbl[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 3'd3, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 3'd3, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 3'd2, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'd0;
    out_ready = 1'b0;

    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
`ifdef STREAM_FIFO_LEVEL_EN
    chk("rst_level", int'(level), 0);
    chk("rst_afull", int'(almost_full), 0);
`endif
    tick();
    reset = 1'b0;
    #1;
    chk("rel_in_ready_pre", int'(in_ready), 0);
    tick();
    chk("rel_in_ready_post", int'(in_ready), 1);
    chk("rel_out_valid", int'(out_valid), 0);

    // fill to full, stall a 5th word, then drain in order
    for (int i = 0; i < 11; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(tbl[i].ir));
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
      if (tbl[i].cd)
        chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(tbl[i].od));
`ifdef STREAM_FIFO_LEVEL_EN
      chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].lv));
      chk($sformatf("vec%0d_afull", i), int'(almost_full), int'(tbl[i].af));
`endif
      tick();
    end

    // single word held under back-pressure
    in_valid  = 1'b1;
    in_data   = 2'd1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("hold%0d_data", i), int'(out_data), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_drained", int'(out_valid), 0);

    // continuous stream of 20 words
    begin
      int sent;
      int cyc;
      sent = 0;
      cyc  = 0;
      out_ready = 1'b1;
      while ((sent < 20 || out_valid) && cyc < 60) begin
        in_valid = (sent < 20);
        in_data  = 2'(sent % 4);
        if (out_valid) rx.push_back(out_data);
        if (in_valid && in_ready) sent++;
        if (sent < 20 && !in_ready) chk("stream_in_ready", 0, 1);
        tick();
        cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_timeout", int'(cyc < 60), 1);
      chk("stream_count", rx.size(), 20);
      for (int i = 0; i < rx.size() && i < 20; i++)
        chk($sformatf("stream_word%0d", i), int'(rx[i]), i % 4);
    end

    // asynchronous reset with three words stored
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 2'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ready", int'(in_ready), 0);
    chk("async_rst_data", int'(out_data), 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_rst%0d_valid", i), int'(out_valid), 0);
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("post_rst_new_valid", int'(out_valid), 1);
    chk("post_rst_new_data", int'(out_data), 2);
    tick();
    chk("post_rst_new_hold", int'(out_data), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
